// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU sharing arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic ALU_CTRL_ADD = 1'b1;
  localparam logic ALU_CTRL_NOP = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the search starts one past ptr and wraps.
// Holds no state; the pointer is owned and updated by the caller.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one integer ALU between NUM_REQ requesters: accept, one EXEC cycle,
// then a held response to the owner until it is taken (1 op per 3 cycles at best).
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
  input  logic [NUM_REQ-1:0]            req_ctrl,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          resp_eq,
  output logic [DATA_WIDTH-1:0]         alu_op1,
  output logic [DATA_WIDTH-1:0]         alu_op2,
  output logic                          alu_ctrl,
  input  logic [DATA_WIDTH-1:0]         alu_out,
  input  logic                          alu_eq
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic                  alu_ctrl_q, alu_ctrl_d;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
  logic                  resp_eq_q, resp_eq_d;

  logic [NUM_REQ-1:0]    grant;
  logic [PW-1:0]         grant_idx;
  logic                  grant_any;
  logic                  accept;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Gated by rst so a request presented during reset is never handshaken.
  assign accept    = (state_q == IDLE) && grant_any && !rst;
  assign req_ready = accept ? grant : '0;

  // The ALU operand registers double as the hold registers: loaded on accept,
  // cleared as EXEC ends so the ALU inputs sit at zero outside EXEC.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    alu_ctrl_d    = alu_ctrl_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_eq_d     = resp_eq_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_op1_d  = req_op1[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          alu_op2_d  = req_op2[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          alu_ctrl_d = req_ctrl[grant_idx] ? ALU_CTRL_ADD : ALU_CTRL_NOP;
          owner_d    = grant_idx;
          rr_ptr_d   = grant_idx;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        resp_result_d         = alu_out;
        resp_eq_d             = alu_eq;
        resp_valid_d          = '0;
        resp_valid_d[owner_q] = 1'b1;
        alu_op1_d             = '0;
        alu_op2_d             = '0;
        alu_ctrl_d            = ALU_CTRL_NOP;
        state_d               = RESP;
      end
      RESP: begin
        if (resp_ready[owner_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = '0;
        alu_op1_d    = '0;
        alu_op2_d    = '0;
        alu_ctrl_d   = ALU_CTRL_NOP;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= PW'(NUM_REQ - 1);
      owner_q       <= '0;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_ctrl_q    <= ALU_CTRL_NOP;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_eq_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      alu_ctrl_q    <= alu_ctrl_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_eq_q     <= resp_eq_d;
    end
  end

  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_eq     = resp_eq_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_op1;
  logic [NR*DW-1:0]  req_op2;
  logic [NR-1:0]     req_ctrl;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready;
  logic [DW-1:0]     resp_result;
  logic              resp_eq;
  logic [DW-1:0]     alu_op1;
  logic [DW-1:0]     alu_op2;
  logic              alu_ctrl;
  logic [DW-1:0]     alu_out;
  logic              alu_eq;

  int n_chk = 0;
  int n_bad = 0;

  alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_ctrl    (req_ctrl),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_eq     (resp_eq),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out),
    .alu_eq      (alu_eq)
  );

  assign alu_out = alu_ctrl ? (alu_op1 + alu_op2) : '0;
  assign alu_eq  = (alu_op1 == alu_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic c);
    req_op1[idx*DW +: DW] = a;
    req_op2[idx*DW +: DW] = b;
    req_ctrl[idx]         = c;
  endtask

  // One complete transaction with resp_ready all ones; vmask may offer competitors.
  task automatic do_txn(input string tag, input logic [NR-1:0] vmask, input int idx,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c,
                        input logic [DW-1:0] exp_res, input logic exp_eq);
    logic [NR-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    set_req(idx, a, b, c);
    req_valid = vmask;
    #1;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(oh));
    tick();
    req_valid = '0;
    #1;
    chk({tag, ".alu_op1"}, 64'(alu_op1), 64'(a));
    chk({tag, ".alu_op2"}, 64'(alu_op2), 64'(b));
    chk({tag, ".alu_ctrl"}, 64'(alu_ctrl), 64'(c));
    chk({tag, ".exec_ready"}, 64'(req_ready), 64'(0));
    tick();
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'(oh));
    chk({tag, ".result"}, 64'(resp_result), 64'(exp_res));
    chk({tag, ".eq"}, 64'(resp_eq), 64'(exp_eq));
    chk({tag, ".alu_idle"}, 64'(alu_op1), 64'(0));
    tick();
    chk({tag, ".resp_done"}, 64'(resp_valid), 64'(0));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    tick();
    chk("rst.req_ready", 64'(req_ready), 64'(0));
    chk("rst.resp_valid", 64'(resp_valid), 64'(0));
    chk("rst.result", 64'(resp_result), 64'(0));
    chk("rst.eq", 64'(resp_eq), 64'(0));
    chk("rst.alu_op1", 64'(alu_op1), 64'(0));
    chk("rst.alu_op2", 64'(alu_op2), 64'(0));
    chk("rst.alu_ctrl", 64'(alu_ctrl), 64'(0));
    tick();
    chk("rst2.resp_valid", 64'(resp_valid), 64'(0));
    rst       = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    req_ctrl   = '0;
    resp_ready = 2'b11;

    do_reset();

    do_txn("add", 2'b01, 0, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0);
    do_txn("wrap", 2'b10, 1, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b0);
    do_txn("nop_eq", 2'b10, 1, 32'h1234, 32'h1234, 1'b0, 32'd0, 1'b1);

    // Valid withdrawn before the edge: no transaction.
    set_req(0, 32'd77, 32'd1, 1'b1);
    req_valid = 2'b01;
    #1;
    chk("drop.offer", 64'(req_ready), 64'(2'b01));
    req_valid = '0;
    #1;
    tick();
    chk("drop.alu_op1", 64'(alu_op1), 64'(0));
    chk("drop.alu_ctrl", 64'(alu_ctrl), 64'(0));
    tick();
    chk("drop.resp_valid", 64'(resp_valid), 64'(0));

    // Both valid continuously: grants alternate 0,1,0,1 every third cycle.
    set_req(0, 32'd10, 32'd1, 1'b1);
    set_req(1, 32'd100, 32'd2, 1'b1);
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 12; c++) begin
      int owner;
      logic [NR-1:0] oh;
      owner = (c / 3) % 2;
      oh = '0;
      oh[owner] = 1'b1;
      case (c % 3)
        0: begin
          chk($sformatf("rr%0d.req_ready", c), 64'(req_ready), 64'(oh));
          chk($sformatf("rr%0d.resp_valid", c), 64'(resp_valid), 64'(0));
        end
        1: begin
          chk($sformatf("rr%0d.alu_op1", c), 64'(alu_op1), owner == 1 ? 64'd100 : 64'd10);
          chk($sformatf("rr%0d.req_ready", c), 64'(req_ready), 64'(0));
        end
        default: begin
          chk($sformatf("rr%0d.resp_valid", c), 64'(resp_valid), 64'(oh));
          chk($sformatf("rr%0d.result", c), 64'(resp_result), owner == 1 ? 64'd102 : 64'd11);
        end
      endcase
      tick();
    end
    req_valid = '0;
    #1;
    chk("rr.end_idle", 64'(req_ready), 64'(0));

    // Backpressure on requester 0 while requester 1 waits; resp_ready[1] is ignored.
    resp_ready = 2'b00;
    set_req(0, 32'd3, 32'd4, 1'b1);
    set_req(1, 32'd1, 32'd1, 1'b1);
    req_valid = 2'b01;
    #1;
    chk("bp.accept", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b10;
    #1;
    chk("bp.exec_ready", 64'(req_ready), 64'(0));
    tick();
    resp_ready = 2'b10;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp%0d.resp_valid", i), 64'(resp_valid), 64'(2'b01));
      chk($sformatf("bp%0d.result", i), 64'(resp_result), 64'd7);
      chk($sformatf("bp%0d.req_ready", i), 64'(req_ready), 64'(0));
      tick();
    end
    resp_ready = 2'b01;
    #1;
    chk("bp.hs_valid", 64'(resp_valid), 64'(2'b01));
    tick();
    chk("bp.resume", 64'(req_ready), 64'(2'b10));
    chk("bp.cleared", 64'(resp_valid), 64'(0));
    tick();
    req_valid  = '0;
    resp_ready = 2'b11;
    tick();
    chk("bp.r1_valid", 64'(resp_valid), 64'(2'b10));
    chk("bp.r1_result", 64'(resp_result), 64'd2);
    chk("bp.r1_eq", 64'(resp_eq), 64'd1);
    tick();

    // Reset during EXEC drops the op and restores requester-0 priority.
    set_req(0, 32'd20, 32'd21, 1'b1);
    set_req(1, 32'd30, 32'd31, 1'b1);
    req_valid = 2'b11;
    #1;
    chk("rx.accept", 64'(req_ready), 64'(2'b01));
    tick();
    rst = 1'b1;
    #1;
    chk("rx.exec_op1", 64'(alu_op1), 64'd20);
    tick();
    rst = 1'b0;
    #1;
    chk("rx.resp_valid", 64'(resp_valid), 64'(0));
    chk("rx.alu_op1", 64'(alu_op1), 64'(0));
    chk("rx.alu_ctrl", 64'(alu_ctrl), 64'(0));
    chk("rx.prio", 64'(req_ready), 64'(2'b01));
    req_valid = '0;
    tick();
    chk("rx.no_resp1", 64'(resp_valid), 64'(0));
    tick();
    chk("rx.no_resp2", 64'(resp_valid), 64'(0));
    chk("rx.no_result", 64'(resp_result), 64'(0));

    // Single valid right after reset, then both valid go to requester 0.
    do_reset();
    do_txn("solo1", 2'b10, 1, 32'd9, 32'd9, 1'b0, 32'd0, 1'b1);
    do_txn("both", 2'b11, 0, 32'd40, 32'd2, 1'b1, 32'd42, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
